// File: rtl/sme_pkg.sv
// Shared definitions for the masked execution unit: randomness width helper,
// the non-zero substitute value and the refresh-RNG state encoding.
package sme_pkg;

    localparam logic [31:0] SME_XS_NONZERO = 32'h6D2B79F5;

    typedef enum logic {
        SEED = 1'b0,
        RUN  = 1'b1
    } sme_rng_state_t;

    // Guard bits consumed per evaluation by a D-share DOM AND over N lanes.
    function automatic int sme_rbits(input int d, input int n);
        return (n * d * (d - 1)) / 2;
    endfunction

endpackage

// File: rtl/sme_xorshift32.sv
// Single combinational xorshift32 step (13, 17, 5).
module sme_xorshift32 (
    input  logic [31:0] x_i,
    output logic [31:0] y_o
);

    logic [31:0] s1_s;
    logic [31:0] s2_s;

    assign s1_s = x_i ^ (x_i << 13);
    assign s2_s = s1_s ^ (s1_s >> 17);
    assign y_o  = s2_s ^ (s2_s << 5);

endmodule

// File: rtl/sme_rng_refresh.sv
// Refresh-randomness source: a bank of xorshift32 generators seeded and
// reseeded from an entropy word stream, feeding the masked AND array.
module sme_rng_refresh
    import sme_pkg::*;
#(
    parameter  int D               = 3,
    parameter  int N               = 32,
    parameter  int RESEED_INTERVAL = 1024,
    localparam int RW              = sme_rbits(D, N),
    localparam int K               = (RW + 31) / 32
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          seed_valid,
    output logic          seed_ready,
    input  logic [31:0]   seed_data,
    input  logic          en,
    output logic          rng_valid,
    output logic [RW-1:0] rng,
    output logic          reseed_req
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = $clog2(RESEED_INTERVAL + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RESEED_INTERVAL);

    sme_rng_state_t state_q, state_d;
    logic [31:0]    gen_q [K];
    logic [31:0]    gen_d [K];
    logic [31:0]    step_s [K];
    logic [IW-1:0]  seed_idx_q, seed_idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           seed_ready_q;
    logic           rng_valid_q, rng_valid_d;
    logic           reseed_req_q, reseed_req_d;
    logic           accept_s;
    logic           wrap_s;
    logic [32*K-1:0] flat_s;

    for (genvar g = 0; g < K; g++) begin : g_xs
        sme_xorshift32 u_xs (
            .x_i (gen_q[g]),
            .y_o (step_s[g])
        );
    end

    assign accept_s = seed_valid && seed_ready_q;
    assign wrap_s   = accept_s && (seed_idx_q == IDX_LAST);

    // Next-state: generator update with zero substitution, seeding index, step budget.
    always_comb begin
        logic [31:0] base_v;
        logic [31:0] mix_v;
        state_d    = state_q;
        seed_idx_d = seed_idx_q;
        cnt_d      = cnt_q;
        for (int i = 0; i < K; i++) begin
            gen_d[i] = gen_q[i];
        end
        base_v = 32'h0;
        mix_v  = 32'h0;
        case (state_q)
            SEED: begin
                for (int i = 0; i < K; i++) begin
                    if (accept_s && (seed_idx_q == IW'(i))) begin
                        gen_d[i] = (seed_data == 32'h0) ? SME_XS_NONZERO : seed_data;
                    end else begin
                        gen_d[i] = gen_q[i];
                    end
                end
                if (wrap_s) begin
                    state_d = RUN;
                end else begin
                    state_d = SEED;
                end
            end
            RUN: begin
                for (int i = 0; i < K; i++) begin
                    base_v = en ? step_s[i] : gen_q[i];
                    if (accept_s && (seed_idx_q == IW'(i))) begin
                        mix_v    = base_v ^ seed_data;
                        gen_d[i] = (mix_v == 32'h0) ? SME_XS_NONZERO : mix_v;
                    end else begin
                        gen_d[i] = base_v;
                    end
                end
                // A completed reseed round refills the budget even if en steps this cycle.
                if (wrap_s) begin
                    cnt_d = {CW{1'b0}};
                end else if (en && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = SEED;
            end
        endcase
        if (accept_s) begin
            seed_idx_d = wrap_s ? {IW{1'b0}} : (seed_idx_q + IW'(1));
        end else begin
            seed_idx_d = seed_idx_q;
        end
        rng_valid_d  = (state_d == RUN);
        reseed_req_d = (cnt_d == CNT_MAX);
    end

    // State, generator bank and registered status outputs.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q      <= SEED;
            seed_idx_q   <= {IW{1'b0}};
            cnt_q        <= {CW{1'b0}};
            seed_ready_q <= 1'b0;
            rng_valid_q  <= 1'b0;
            reseed_req_q <= 1'b0;
            for (int i = 0; i < K; i++) begin
                gen_q[i] <= 32'h0;
            end
        end else begin
            state_q      <= state_d;
            seed_idx_q   <= seed_idx_d;
            cnt_q        <= cnt_d;
            seed_ready_q <= 1'b1;
            rng_valid_q  <= rng_valid_d;
            reseed_req_q <= reseed_req_d;
            for (int i = 0; i < K; i++) begin
                gen_q[i] <= gen_d[i];
            end
        end
    end

    // Flatten the bank; generator 0 lands in the low word.
    always_comb begin
        flat_s = {(32*K){1'b0}};
        for (int i = 0; i < K; i++) begin
            flat_s[32*i +: 32] = gen_q[i];
        end
    end

    assign rng        = flat_s[RW-1:0];
    assign seed_ready = seed_ready_q;
    assign rng_valid  = rng_valid_q;
    assign reseed_req = reseed_req_q;

endmodule

// File: tb/tb_sme_rng_refresh.sv
// Randomized self-checking bench for sme_rng_refresh against a word-level model.
module tb_sme_rng_refresh;

    localparam int D  = 3;
    localparam int N  = 32;
    localparam int RI = 4;
    localparam int RW = 96;
    localparam int K  = 3;
    localparam logic [31:0] NZ = 32'h6D2B79F5;

    logic          g_clk = 1'b0;
    logic          g_resetn = 1'b0;
    logic          seed_valid = 1'b0;
    logic          seed_ready;
    logic [31:0]   seed_data = 32'h0;
    logic          en = 1'b0;
    logic          rng_valid;
    logic [RW-1:0] rng;
    logic          reseed_req;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_gen [K];
    int          m_idx;
    int          m_cnt;
    bit          m_run;
    bit          m_ready;

    sme_rng_refresh #(.D(D), .N(N), .RESEED_INTERVAL(RI)) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_data  (seed_data),
        .en         (en),
        .rng_valid  (rng_valid),
        .rng        (rng),
        .reseed_req (reseed_req)
    );

    always #5 g_clk = ~g_clk;

    task automatic check_eq(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < K; i++) m_gen[i] = 32'h0;
        m_idx = 0; m_cnt = 0; m_run = 0; m_ready = 0;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".rng"}, rng, {m_gen[2], m_gen[1], m_gen[0]});
        check_eq({tag, ".valid"}, {95'd0, rng_valid}, {95'd0, m_run});
        check_eq({tag, ".reseed"}, {95'd0, reseed_req}, {95'd0, (m_cnt == RI)});
        check_eq({tag, ".ready"}, {95'd0, seed_ready}, {95'd0, m_ready});
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled, then compare.
    task automatic tick(input string tag);
        bit          acc;
        logic [31:0] v;
        @(posedge g_clk);
        acc = seed_valid && m_ready;
        if (!m_run) begin
            if (acc) begin
                m_gen[m_idx] = (seed_data == 32'h0) ? NZ : seed_data;
                if (m_idx == K - 1) begin m_idx = 0; m_run = 1; end
                else m_idx++;
            end
        end else begin
            if (en) begin
                for (int i = 0; i < K; i++) m_gen[i] = xs(m_gen[i]);
                if (m_cnt < RI) m_cnt++;
            end
            if (acc) begin
                v = m_gen[m_idx] ^ seed_data;
                m_gen[m_idx] = (v == 32'h0) ? NZ : v;
                if (m_idx == K - 1) begin m_idx = 0; m_cnt = 0; end
                else m_idx++;
            end
        end
        m_ready = 1;
        #1;
        compare_all(tag);
    endtask

    task automatic send_word(input logic [31:0] data, input logic en_v);
        bit done;
        done = 0;
        seed_valid = 1'b1; seed_data = data; en = en_v;
        for (int t = 0; t < 4 && !done; t++) begin
            done = m_ready;
            tick("seed");
        end
        if (!done) check_eq("seed_accept_timeout", {95'd0, seed_ready}, {95'd0, 1'b1});
        seed_valid = 1'b0; en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge g_clk);
        #3;
        seed_valid = 1'b0; en = 1'b0;
        g_resetn = 1'b0;
        #1;
        check_eq("rst.rng", rng, {RW{1'b0}});
        check_eq("rst.valid", {95'd0, rng_valid}, 96'd0);
        check_eq("rst.reseed", {95'd0, reseed_req}, 96'd0);
        check_eq("rst.ready", {95'd0, seed_ready}, 96'd0);
        model_reset();
        #3;
        g_resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        model_reset();
        #2;
        check_eq("por.rng", rng, {RW{1'b0}});
        check_eq("por.valid", {95'd0, rng_valid}, 96'd0);
        check_eq("por.ready", {95'd0, seed_ready}, 96'd0);
        #10;
        g_resetn = 1'b1;

        // Basic seeding and first step.
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        check_eq("valid_before_third", {95'd0, rng_valid}, 96'd0);
        send_word(32'd3, 1'b0);
        check_eq("valid_after_third", {95'd0, rng_valid}, 96'd1);
        check_eq("g0_seed", {64'd0, rng[31:0]}, 96'd1);
        check_eq("g1_seed", {64'd0, rng[63:32]}, 96'd2);
        check_eq("g2_seed", {64'd0, rng[95:64]}, 96'd3);
        en = 1'b1; tick("en1"); en = 1'b0;
        check_eq("g0_step", {64'd0, rng[31:0]}, {64'd0, 32'h00042021});

        // Same-cycle step and seed cancelling to zero.
        do_reset();
        send_word(32'd1, 1'b0); send_word(32'd2, 1'b0); send_word(32'd3, 1'b0);
        send_word(32'h00042021, 1'b1);
        check_eq("zero_subst", {64'd0, rng[31:0]}, {64'd0, NZ});

        // Zero seed word and en ignored in SEED.
        do_reset();
        send_word(32'd0, 1'b1);
        check_eq("seed0_subst", {64'd0, rng[31:0]}, {64'd0, NZ});
        send_word(32'd5, 1'b1);
        send_word(32'd7, 1'b1);
        check_eq("seed_en_ignored", {32'd0, rng[95:32]}, {32'd0, 32'd7, 32'd5});

        // Step budget exhaustion and reseed clearing.
        en = 1'b1;
        for (int i = 0; i < 3; i++) tick("budget");
        check_eq("reseed_before", {95'd0, reseed_req}, 96'd0);
        tick("budget");
        check_eq("reseed_set", {95'd0, reseed_req}, 96'd1);
        tick("saturate"); tick("saturate");
        en = 1'b0;
        send_word(32'h1111_0000, 1'b0);
        send_word(32'h2222_0000, 1'b0);
        check_eq("reseed_held", {95'd0, reseed_req}, 96'd1);
        send_word(32'h3333_0000, 1'b1);
        check_eq("reseed_cleared", {95'd0, reseed_req}, 96'd0);

        // Randomized traffic, including zero-forcing words and mid-run resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                en = 1'($urandom_range(0, 1));
                seed_valid = ($urandom_range(0, 3) == 0);
                d = $urandom;
                case ($urandom_range(0, 7))
                    0: d = 32'h0;
                    1: d = (m_run && en) ? xs(m_gen[m_idx]) : m_gen[m_idx];
                    default: d = $urandom;
                endcase
                seed_data = d;
                tick("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sme_rng_refresh.md
# sme_rng_refresh

Refresh-randomness source for the masked execution unit. It keeps a bank of xorshift32 generators, seeded and reseeded from an external entropy word stream. It supplies the `D*(D-1)/2` guard bits per bit-lane that each DOM AND stage consumes per evaluation. It sits directly upstream of the masked AND array, and its `rng` output drives that array's `rng` input bit-for-bit.

## Interface
Parameters:
- `D`, 3, number of shares.
- `N`, 32, operand width.
- `RESEED_INTERVAL`, 1024, number of generator steps after which a reseed is requested.
- Derived: `RW = N*D*(D-1)/2` (96 at defaults).
- Derived: `K = ceil(RW/32)` generators.

Ports:
- `g_clk` in 1: global clock, posedge.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `seed_valid` in 1: entropy word offered.
- `seed_ready` out 1: entropy word accepted when `seed_valid && seed_ready`.
- `seed_data` in 32: entropy word.
- `en` in 1: consume current `rng` and step all generators.
- `rng_valid` out 1: `rng` holds seeded randomness.
- `rng` out RW: concatenated generator states, generator 0 in bits [31:0]; high bits of the last generator unused.
- `reseed_req` out 1: step budget exhausted; a reseed round is wanted.

## Operation
- States: SEED (reset state) and RUN.
- Reset values: state=SEED, all generator states 0, `seed_idx`=0, step counter 0, `seed_ready`=0, `rng_valid`=0, `rng`=0, `reseed_req`=0.
- `seed_ready` is registered. It becomes 1 on the first clock edge after reset deasserts and then stays 1.
- SEED:
  - Each accepted word loads generator `seed_idx`; `seed_idx` then increments.
  - A word of 0 loads `32'h6D2B79F5` instead.
  - `en` is ignored.
  - On acceptance with `seed_idx==K-1`, the next state is RUN and `seed_idx` wraps to 0.
- RUN:
  - `rng_valid`=1.
  - `en` steps every generator once. Step: `x^=x<<13; x^=x>>17; x^=x<<5`.
  - An accepted word is XORed into generator `seed_idx`; `seed_idx` increments mod K.
  - If `en` and a seed word hit the same cycle, the new value of that generator is `step(x)^seed_data`.
  - Any XOR result of 0 is replaced by `32'h6D2B79F5`. Generator states are never 0 in RUN.
- Step counter:
  - Increments on `en` in RUN and saturates at RESEED_INTERVAL.
  - `reseed_req` is 1 while counter==RESEED_INTERVAL.
  - When an accepted word wraps `seed_idx` from K-1 to 0, the counter and `reseed_req` clear in that cycle. This takes priority over a simultaneous `en` increment.
- Generation continues while `reseed_req`=1; no stalling.
- The block never returns to SEED except through reset.

## Timing
- `rng` is the generator state register, with no output logic.
- After `en` is sampled at edge t, new randomness is visible after edge t. Every `en` cycle sees fresh bits, with one step per cycle at full throughput.
- `rng_valid` rises on the edge that accepts the K-th seed word. Minimum latency from reset release is K+1 edges.
- A seed acceptance alters `rng` after the same edge.
- Asserting reset mid-operation immediately (asynchronously) forces all outputs to their reset values and discards any partial seeding round.
- `reseed_req` asserts on the edge where the counter reaches RESEED_INTERVAL.

## Structure
- Shared package `sme_pkg` holds:
  - function `sme_rbits(D,N)` returning `N*D*(D-1)/2`;
  - constant `SME_XS_NONZERO = 32'h6D2B79F5`;
  - enum `sme_rng_state_t {SEED, RUN}`.
- One sub-module, `sme_xorshift32`: a combinational single-step function, 32-bit in and 32-bit out, instantiated K times.
- Top-level block: FSM, `seed_idx` counter, step counter, zero-substitution, and the generator registers.

## Test plan
- Reset, then seed 1,2,3 (D=3, N=32, K=3):
  - `rng_valid` rises after the third acceptance;
  - `rng[31:0]`=1, `rng[63:32]`=2, `rng[95:64]`=3;
  - one `en` gives `rng[31:0]`=`32'h00042021`.
- Seed word 0 during SEED → that generator holds `32'h6D2B79F5`; `en` held high in SEED leaves `rng` unchanged.
- RUN, `en`=1 and seed `32'h00042021` to generator 0 holding 1 in the same cycle → generator 0 = `32'h00042021^32'h00042021` → 0 → substituted `32'h6D2B79F5`.
- RESEED_INTERVAL=4:
  - 4 `en` pulses → `reseed_req`=1, and further `en` keeps stepping with the counter saturated;
  - 3 seed words → `reseed_req`=0 on the third acceptance edge, even with `en` high in that cycle.
- Assert `g_resetn` low mid-RUN between clock edges → `rng`=0, `rng_valid`=0, `reseed_req`=0 immediately, `seed_ready`=0; re-seeding restarts at generator 0.
